// File: rtl/seg_disp_pkg.sv
// Shared character set for the 8-digit seven-segment display: 6-bit codes and active-low glyphs.
// Glyph bit order is {CG,CF,CE,CD,CC,CB,CA}; a 0 lights the segment.
package seg_disp_pkg;

  typedef logic [5:0] char_t;

  localparam char_t CH_BLANK = 6'd10;
  localparam char_t CH_A     = 6'd11;
  localparam char_t CH_B     = 6'd12;
  localparam char_t CH_F     = 6'd16;
  localparam char_t CH_H     = 6'd18;
  localparam char_t CH_K     = 6'd21;
  localparam char_t CH_M     = 6'd23;
  localparam char_t CH_W     = 6'd33;
  localparam char_t CH_Z     = 6'd36;
  localparam char_t CH_DASH  = 6'd37;

  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;

  // Digits 0-9, BLANK, then A-Z; K, M, W and X are approximations.
  localparam logic [6:0] GLYPH_TABLE [0:36] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
    7'b1111111,
    7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110,
    7'b0001110, 7'b1000010, 7'b0001001, 7'b1001111, 7'b1100001,
    7'b0001010, 7'b1000111, 7'b1001000, 7'b0101011, 7'b0100011,
    7'b0001100, 7'b0011000, 7'b0101111, 7'b0010010, 7'b0000111,
    7'b1000001, 7'b1100011, 7'b1010101, 7'b0110110, 7'b0010001,
    7'b0100100
  };

endpackage

// File: rtl/seg_char_decode.sv
// Combinational character-code to cathode decoder; codes past Z render as a dash.
module seg_char_decode
  import seg_disp_pkg::*;
(
  input  char_t      i_char,
  output logic [6:0] o_cat
);

  always_comb begin
    o_cat = GLYPH_DASH;
    if (i_char <= CH_Z) o_cat = GLYPH_TABLE[i_char];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit common-anode display driver with frame snapshot and dead-time gaps.
// Optional whole-display blink is built only when SEG_SCAN_BLINK_EN is defined.
module seg_scan_driver
  import seg_disp_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1024,
  parameter int BLINK_CYCLES = 16000000
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  char_t [7:0]     seg_data_in,
  input  logic            blink_in,
  output logic [6:0]      cat_out,
  output logic [7:0]      an_out,
  output logic            frame_tick_out
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

  logic [CW-1:0]  r_cnt;
  logic [2:0]     r_dig;
  char_t [7:0]    r_snap;
  logic [6:0]     w_glyph;
  logic           w_slot_end;
  logic           w_gap;
  logic           w_capture;
  logic           w_blink_off;

  assign w_slot_end = (r_cnt == CW'(DIGIT_CYCLES - 1));
  assign w_gap      = (r_cnt < CW'(BLANK_CYCLES));
  assign w_capture  = (r_cnt == '0) && (r_dig == 3'd0);

  seg_char_decode u_decode (
    .i_char (r_snap[r_dig]),
    .o_cat  (w_glyph)
  );

`ifdef SEG_SCAN_BLINK_EN
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [BW-1:0] r_blink_cnt;
  logic          r_phase_on;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_blink_cnt <= '0;
      r_phase_on  <= 1'b1;
    end else if (r_blink_cnt == BW'(BLINK_CYCLES - 1)) begin
      r_blink_cnt <= '0;
      r_phase_on  <= ~r_phase_on;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  assign w_blink_off = blink_in & ~r_phase_on;
`else
  assign w_blink_off = blink_in & 1'b0;
`endif

  // Outputs are computed from the pre-edge counter state, so they lag it by one cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cnt          <= '0;
      r_dig          <= 3'd0;
      r_snap         <= {8{CH_BLANK}};
      an_out         <= 8'hFF;
      cat_out        <= 7'h7F;
      frame_tick_out <= 1'b0;
    end else begin
      if (w_slot_end) begin
        r_cnt <= '0;
        r_dig <= r_dig + 3'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      frame_tick_out <= w_capture;
      if (w_capture) r_snap <= seg_data_in;

      if (w_gap) begin
        an_out  <= 8'hFF;
        cat_out <= GLYPH_BLANK;
      end else begin
        an_out  <= w_blink_off ? 8'hFF : ~(8'd1 << r_dig);
        cat_out <= w_glyph;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIGIT_CYCLES=8, BLANK_CYCLES=2, BLINK_CYCLES=64.
module tb_seg_scan_driver;

  logic             clk;
  logic             rst;
  logic [7:0][5:0]  seg_data;
  logic             blink;
  logic [6:0]       cat;
  logic [7:0]       an;
  logic             ftick;

  int n_checks = 0;
  int n_pass   = 0;

  seg_scan_driver #(
    .DIGIT_CYCLES (8),
    .BLANK_CYCLES (2),
    .BLINK_CYCLES (64)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .seg_data_in    (seg_data),
    .blink_in       (blink),
    .cat_out        (cat),
    .an_out         (an),
    .frame_tick_out (ftick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    rst   = 1'b1;
    blink = 1'b0;
    for (int i = 0; i < 8; i++) seg_data[i] = 6'(i);

    #2;
    chk("reset_an",   an, 8'hFF);
    chk("reset_cat",  {1'b0, cat}, 8'h7F);
    chk("reset_tick", {7'd0, ftick}, 8'h00);
    tick(3);
    rst = 1'b0;

    tick(1); // edge 1: first capture
    chk("first_tick", {7'd0, ftick}, 8'h01);
    chk("gap0_an", an, 8'hFF);
    tick(1); // edge 2
    chk("tick_once", {7'd0, ftick}, 8'h00);
    chk("gap1_an", an, 8'hFF);
    tick(1); // edge 3
    chk("d0_an", an, 8'b11111110);
    chk("d0_cat", {1'b0, cat}, {1'b0, 7'b1000000});
    tick(5); // edge 8
    chk("d0_end_an", an, 8'b11111110);
    tick(1); // edge 9
    chk("d1_gap_an", an, 8'hFF);
    chk("d1_gap_cat", {1'b0, cat}, 8'h7F);
    tick(1); // edge 10
    chk("d1_gap2_an", an, 8'hFF);
    tick(1); // edge 11
    chk("d1_an", an, 8'b11111101);
    chk("d1_cat", {1'b0, cat}, {1'b0, 7'b1111001});
    seg_data[3] = 6'd8;
    tick(16); // edge 27
    chk("d3_old_an", an, 8'b11110111);
    chk("d3_old_cat", {1'b0, cat}, {1'b0, 7'b0110000});
    tick(37); // edge 64
    chk("no_tick_64", {7'd0, ftick}, 8'h00);
    tick(1); // edge 65: second capture
    chk("tick_65", {7'd0, ftick}, 8'h01);
    chk("gap_65_an", an, 8'hFF);
    tick(26); // edge 91
    chk("d3_new_an", an, 8'b11110111);
    chk("d3_new_cat", {1'b0, cat}, {1'b0, 7'b0000000});
    seg_data[2] = 6'd10;
    seg_data[4] = 6'd50;
    seg_data[5] = 6'd11;
    tick(8); // edge 99
    chk("d4_old_an", an, 8'b11101111);
    chk("d4_old_cat", {1'b0, cat}, {1'b0, 7'b0011001});
    tick(48); // edge 147
    chk("blank_an", an, 8'b11111011);
    chk("blank_cat", {1'b0, cat}, 8'h7F);
    tick(16); // edge 163
    chk("dash_an", an, 8'b11101111);
    chk("dash_cat", {1'b0, cat}, {1'b0, 7'b0111111});
    tick(8); // edge 171
    chk("a_an", an, 8'b11011111);
    chk("a_cat", {1'b0, cat}, {1'b0, 7'b0001000});

    #2;
    rst = 1'b1;
    #1;
    chk("midrst_an", an, 8'hFF);
    chk("midrst_cat", {1'b0, cat}, 8'h7F);
    seg_data[0] = 6'd7;
    @(negedge clk);
    rst = 1'b0;
    tick(1); // edge 1 after release
    chk("rst_tick", {7'd0, ftick}, 8'h01);
    tick(2); // edge 3
    chk("rst_d0_an", an, 8'b11111110);
    chk("rst_d0_cat", {1'b0, cat}, {1'b0, 7'b1111000});

    blink = 1'b1;
    tick(64); // edge 67: blink phase off under the macro
`ifdef SEG_SCAN_BLINK_EN
    chk("blink_off_an", an, 8'hFF);
`else
    chk("blink_off_an", an, 8'b11111110);
`endif
    chk("blink_off_cat", {1'b0, cat}, {1'b0, 7'b1111000});
    tick(64); // edge 131: blink phase on
    chk("blink_on_an", an, 8'b11111110);
    blink = 1'b0;
    tick(64); // edge 195: phase off, but blink not requested
    chk("blink_idle_an", an, 8'b11111110);
    chk("blink_idle_cat", {1'b0, cat}, {1'b0, 7'b1111000});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
